// File: rtl/mpu_pkg.sv
// Shared opcode encodings and FSM state type for the multicycle MPU.
package mpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LDI  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_MOV  = 4'd7,
    OP_JMP  = 4'd8,
    OP_JZ   = 4'd9,
    OP_JC   = 4'd10,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int OPCODE_W = 4;

  function automatic logic writes_reg(input logic [OPCODE_W-1:0] op);
    return (op >= 4'd1) && (op <= 4'd7);
  endfunction

endpackage

// File: rtl/mpu_multicycle_if.sv
// Instruction fetch bus between the MPU (master) and instruction memory (slave).
interface mpu_multicycle_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_req;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_data;

  modport master (output instr_addr, output instr_req, input instr_valid, input instr_data);
  modport slave  (input instr_addr, input instr_req, output instr_valid, output instr_data);
endinterface

// File: rtl/mpu_alu.sv
// Combinational datapath for the register-writing opcodes (LDI..MOV).
module mpu_alu
  import mpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [DATA_W-1:0]   imm,
  output logic [DATA_W-1:0]   value,
  output logic                carry,
  output logic                zero
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // The extra MSB of the difference is the unsigned borrow (a < b).
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Opcode-selected result and carry; logic ops, MOV and LDI leave carry clear.
  always_comb begin
    value = {DATA_W{1'b0}};
    carry = 1'b0;
    case (op)
      OP_LDI: value = imm;
      OP_ADD: begin
        value = sum_s[DATA_W-1:0];
        carry = sum_s[DATA_W];
      end
      OP_SUB: begin
        value = diff_s[DATA_W-1:0];
        carry = diff_s[DATA_W];
      end
      OP_AND: value = a & b;
      OP_OR:  value = a | b;
      OP_XOR: value = a ^ b;
      OP_MOV: value = b;
      default: begin
        value = {DATA_W{1'b0}};
        carry = 1'b0;
      end
    endcase
  end

  assign zero = (value == {DATA_W{1'b0}});

endmodule

// File: rtl/mpu_multicycle.sv
// Two-cycle-per-instruction MPU: FETCH waits for the instruction, EXEC runs it in one cycle.
module mpu_multicycle
  import mpu_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  mpu_multicycle_if.master  bus,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              illegal
);

  localparam int RIDX_W  = $clog2(NUM_REGS);
  localparam int INSTR_W = OPCODE_W + 2 * RIDX_W + DATA_W;

  state_e              state_r, state_next_s;
  logic [ADDR_W-1:0]   pc_r, pc_next_s, pc_inc_s, jump_tgt_s;
  logic [INSTR_W-1:0]  ir_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [OPCODE_W-1:0] op_s;
  logic [RIDX_W-1:0]   rd_s, rs_s;
  logic [DATA_W-1:0]   imm_s;
  logic [DATA_W-1:0]   alu_value_s;
  logic                alu_carry_s, alu_zero_s;
  logic                wr_en_s, illegal_set_s;
  logic [DATA_W-1:0]   result_r;
  logic                result_valid_r, zero_r, carry_r, halted_r, illegal_r, instr_req_r;

  // Everything in EXEC decodes from the captured copy, never from the live bus.
  assign op_s       = ir_r[INSTR_W-1 -: OPCODE_W];
  assign rd_s       = ir_r[DATA_W+RIDX_W +: RIDX_W];
  assign rs_s       = ir_r[DATA_W +: RIDX_W];
  assign imm_s      = ir_r[DATA_W-1:0];
  assign pc_inc_s   = pc_r + ADDR_W'(1);
  assign jump_tgt_s = imm_s[ADDR_W-1:0];

  mpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op_s),
    .a     (regs_r[rd_s]),
    .b     (regs_r[rs_s]),
    .imm   (imm_s),
    .value (alu_value_s),
    .carry (alu_carry_s),
    .zero  (alu_zero_s)
  );

  // Next-state, next-PC and write-enable decode.
  always_comb begin
    state_next_s  = state_r;
    pc_next_s     = pc_r;
    wr_en_s       = 1'b0;
    illegal_set_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (bus.instr_valid) state_next_s = ST_EXEC;
        else                 state_next_s = ST_FETCH;
      end
      ST_EXEC: begin
        state_next_s = ST_FETCH;
        pc_next_s    = pc_inc_s;
        case (op_s)
          OP_NOP: pc_next_s = pc_inc_s;
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: wr_en_s = writes_reg(op_s);
          OP_JMP: pc_next_s = jump_tgt_s;
          OP_JZ: begin
            if (zero_r) pc_next_s = jump_tgt_s;
            else        pc_next_s = pc_inc_s;
          end
          OP_JC: begin
            if (carry_r) pc_next_s = jump_tgt_s;
            else         pc_next_s = pc_inc_s;
          end
          OP_HALT: begin
            state_next_s = ST_HALT;
            pc_next_s    = pc_r;
          end
          default: illegal_set_s = 1'b1;
        endcase
      end
      ST_HALT: state_next_s = ST_HALT;
      default: state_next_s = ST_FETCH;
    endcase
  end

  // Control state: FSM, PC, instruction capture and the registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      pc_r        <= {ADDR_W{1'b0}};
      ir_r        <= {INSTR_W{1'b0}};
      instr_req_r <= 1'b1;
      halted_r    <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      instr_req_r <= (state_next_s == ST_FETCH);
      halted_r    <= (state_next_s == ST_HALT);
      if (state_r == ST_FETCH && bus.instr_valid) ir_r <= bus.instr_data;
      if (illegal_set_s) illegal_r <= 1'b1;
    end
  end

  // Datapath state: register file, last result and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= {DATA_W{1'b0}};
      result_r       <= {DATA_W{1'b0}};
      result_valid_r <= 1'b0;
      zero_r         <= 1'b0;
      carry_r        <= 1'b0;
    end else begin
      result_valid_r <= wr_en_s;
      if (wr_en_s) begin
        regs_r[rd_s] <= alu_value_s;
        result_r     <= alu_value_s;
        zero_r       <= alu_zero_s;
        carry_r      <= alu_carry_s;
      end
    end
  end

  assign bus.instr_addr = pc_r;
  assign bus.instr_req  = instr_req_r;
  assign result         = result_r;
  assign result_valid   = result_valid_r;
  assign zero_flag      = zero_r;
  assign carry_flag     = carry_r;
  assign halted         = halted_r;
  assign illegal        = illegal_r;

endmodule

// File: tb/tb_mpu_multicycle.sv
// Directed bench for mpu_multicycle: a vector table on an 8-bit-PC instance, a 4-bit-PC instance for wrap.
module tb_mpu_multicycle;
  import mpu_pkg::*;

  localparam int IW = 16;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  res;
    logic        rv;
    logic        z;
    logic        c;
    logic [7:0]  pc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_result, b_result;
  logic a_rv, a_z, a_c, a_halted, a_illegal;
  logic b_rv, b_z, b_c, b_halted, b_illegal;

  mpu_multicycle_if #(.ADDR_W(8), .INSTR_W(IW)) bus_a ();
  mpu_multicycle_if #(.ADDR_W(4), .INSTR_W(IW)) bus_b ();

  mpu_multicycle #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(8)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master), .result(a_result), .result_valid(a_rv),
    .zero_flag(a_z), .carry_flag(a_c), .halted(a_halted), .illegal(a_illegal));

  mpu_multicycle #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master), .result(b_result), .result_valid(b_rv),
    .zero_flag(b_z), .carry_flag(b_c), .halted(b_halted), .illegal(b_illegal));

  int checks = 0;
  int failures = 0;
  int rv_count = 0;
  int rv_base;
  vec_t vecs[16];

  always @(negedge clk) if (a_rv) rv_count <= rv_count + 1;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Issue one instruction to DUT d (0 = a, 1 = b); returns at the negedge after EXEC.
  task automatic issue(input int d, input logic [15:0] ins);
    int n = 0;
    while (!(d == 0 ? bus_a.instr_req : bus_b.instr_req) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_wait", 32'(n < 50), 32'd1);
    if (d == 0) begin bus_a.instr_valid = 1'b1; bus_a.instr_data = ins; end
    else        begin bus_b.instr_valid = 1'b1; bus_b.instr_data = ins; end
    @(negedge clk);
    bus_a.instr_valid = 1'b0; bus_a.instr_data = 16'h0000;
    bus_b.instr_valid = 1'b0; bus_b.instr_data = 16'h0000;
    @(negedge clk);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_addr"}, 32'(bus_a.instr_addr), 32'd0);
    chk({tag, "_req"}, 32'(bus_a.instr_req), 32'd1);
    chk({tag, "_result"}, 32'(a_result), 32'd0);
    chk({tag, "_rv"}, 32'(a_rv), 32'd0);
    chk({tag, "_zero"}, 32'(a_z), 32'd0);
    chk({tag, "_carry"}, 32'(a_c), 32'd0);
    chk({tag, "_halted"}, 32'(a_halted), 32'd0);
    chk({tag, "_illegal"}, 32'(a_illegal), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{enc(OP_LDI, 2'd0, 2'd0, 8'd200), 8'd200, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[1]  = '{enc(OP_LDI, 2'd1, 2'd0, 8'd100), 8'd100, 1'b1, 1'b0, 1'b0, 8'h02};
    vecs[2]  = '{enc(OP_ADD, 2'd0, 2'd1, 8'd0),   8'd44,  1'b1, 1'b0, 1'b1, 8'h03};
    vecs[3]  = '{enc(OP_LDI, 2'd2, 2'd0, 8'd5),   8'd5,   1'b1, 1'b0, 1'b0, 8'h04};
    vecs[4]  = '{enc(OP_SUB, 2'd2, 2'd2, 8'd0),   8'd0,   1'b1, 1'b1, 1'b0, 8'h05};
    vecs[5]  = '{enc(OP_JZ,  2'd0, 2'd0, 8'h10),  8'd0,   1'b0, 1'b1, 1'b0, 8'h10};
    vecs[6]  = '{enc(OP_SUB, 2'd1, 2'd0, 8'd0),   8'd56,  1'b1, 1'b0, 1'b0, 8'h11};
    vecs[7]  = '{enc(OP_SUB, 2'd0, 2'd1, 8'd0),   8'd244, 1'b1, 1'b0, 1'b1, 8'h12};
    vecs[8]  = '{enc(OP_JC,  2'd0, 2'd0, 8'h30),  8'd244, 1'b0, 1'b0, 1'b1, 8'h30};
    vecs[9]  = '{enc(OP_JZ,  2'd0, 2'd0, 8'h50),  8'd244, 1'b0, 1'b0, 1'b1, 8'h31};
    vecs[10] = '{enc(OP_AND, 2'd0, 2'd1, 8'd0),   8'h30,  1'b1, 1'b0, 1'b0, 8'h32};
    vecs[11] = '{enc(OP_OR,  2'd2, 2'd1, 8'd0),   8'h38,  1'b1, 1'b0, 1'b0, 8'h33};
    vecs[12] = '{enc(OP_XOR, 2'd2, 2'd1, 8'd0),   8'h00,  1'b1, 1'b1, 1'b0, 8'h34};
    vecs[13] = '{enc(OP_MOV, 2'd3, 2'd0, 8'd0),   8'h30,  1'b1, 1'b0, 1'b0, 8'h35};
    vecs[14] = '{enc(OP_NOP, 2'd0, 2'd0, 8'd0),   8'h30,  1'b0, 1'b0, 1'b0, 8'h36};
    vecs[15] = '{enc(OP_JMP, 2'd0, 2'd0, 8'h05),  8'h30,  1'b0, 1'b0, 1'b0, 8'h05};

    rst = 1'b1;
    bus_a.instr_valid = 1'b0; bus_a.instr_data = 16'h0000;
    bus_b.instr_valid = 1'b0; bus_b.instr_data = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_a("reset");
    chk("reset_b_addr", 32'(bus_b.instr_addr), 32'd0);
    chk("reset_b_req", 32'(bus_b.instr_req), 32'd1);

    rv_base = rv_count;
    for (int i = 0; i < 16; i++) begin
      issue(0, vecs[i].ins);
      chk($sformatf("v%0d_result", i), 32'(a_result), 32'(vecs[i].res));
      chk($sformatf("v%0d_rv", i), 32'(a_rv), 32'(vecs[i].rv));
      chk($sformatf("v%0d_zero", i), 32'(a_z), 32'(vecs[i].z));
      chk($sformatf("v%0d_carry", i), 32'(a_c), 32'(vecs[i].c));
      chk($sformatf("v%0d_pc", i), 32'(bus_a.instr_addr), 32'(vecs[i].pc));
      if (i == 2) begin
        #1;
        chk("rv_pulses_after_add", 32'(rv_count - rv_base), 32'd3);
      end
    end

    // Fetch stall: instr_valid low for 5 cycles at PC 5.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_addr", k), 32'(bus_a.instr_addr), 32'h05);
      chk($sformatf("stall%0d_req", k), 32'(bus_a.instr_req), 32'd1);
      chk($sformatf("stall%0d_rv", k), 32'(a_rv), 32'd0);
    end
    issue(0, enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    issue(0, enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    chk("pre_halt_addr", 32'(bus_a.instr_addr), 32'h07);
    issue(0, enc(OP_HALT, 2'd0, 2'd0, 8'd0));
    bus_a.instr_valid = 1'b1;
    bus_a.instr_data  = enc(OP_LDI, 2'd0, 2'd0, 8'hAA);
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("halt%0d_halted", k), 32'(a_halted), 32'd1);
      chk($sformatf("halt%0d_req", k), 32'(bus_a.instr_req), 32'd0);
      chk($sformatf("halt%0d_addr", k), 32'(bus_a.instr_addr), 32'h07);
      chk($sformatf("halt%0d_rv", k), 32'(a_rv), 32'd0);
      @(negedge clk);
    end
    bus_a.instr_valid = 1'b0;
    bus_a.instr_data  = 16'h0000;

    // PC wrap and illegal opcode on the 4-bit-PC instance.
    issue(1, enc(OP_JMP, 2'd0, 2'd0, 8'h0F));
    chk("b_jmp_addr", 32'(bus_b.instr_addr), 32'hF);
    issue(1, enc(OP_NOP, 2'd0, 2'd0, 8'd0));
    chk("b_wrap_addr", 32'(bus_b.instr_addr), 32'h0);
    issue(1, enc(OP_LDI, 2'd1, 2'd0, 8'h5A));
    chk("b_ldi_result", 32'(b_result), 32'h5A);
    chk("b_pre_illegal", 32'(b_illegal), 32'd0);
    issue(1, enc(4'd12, 2'd1, 2'd1, 8'hFF));
    chk("b_illegal", 32'(b_illegal), 32'd1);
    chk("b_illegal_rv", 32'(b_rv), 32'd0);
    chk("b_illegal_addr", 32'(bus_b.instr_addr), 32'h2);
    chk("b_illegal_result", 32'(b_result), 32'h5A);
    chk("b_illegal_zero", 32'(b_z), 32'd0);
    issue(1, enc(OP_MOV, 2'd0, 2'd1, 8'd0));
    chk("b_reg_unchanged", 32'(b_result), 32'h5A);
    chk("b_illegal_sticky", 32'(b_illegal), 32'd1);

    // Reset in the middle of an ADD's EXEC cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_a("rst2");
    issue(0, enc(OP_LDI, 2'd0, 2'd0, 8'd9));
    issue(0, enc(OP_LDI, 2'd1, 2'd0, 8'd250));
    chk("pre_abort_addr", 32'(bus_a.instr_addr), 32'h02);
    bus_a.instr_valid = 1'b1;
    bus_a.instr_data  = enc(OP_ADD, 2'd0, 2'd1, 8'd0);
    @(negedge clk);
    bus_a.instr_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_a("abort");
    @(negedge clk);
    issue(0, enc(OP_MOV, 2'd2, 2'd0, 8'd0));
    chk("abort_r0_result", 32'(a_result), 32'd0);
    chk("abort_r0_zero", 32'(a_z), 32'd1);
    chk("abort_r0_carry", 32'(a_c), 32'd0);
    chk("abort_next_addr", 32'(bus_a.instr_addr), 32'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpu_multicycle.md
MPU_MULTICYCLE -- requirements
Module: mpu_multicycle

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, datapath and register width (4..32).
REQ-002 The block SHALL have parameter NUM_REGS, default 4, general registers (power of two, 2..16); RIDX_W = clog2(NUM_REGS).
REQ-003 The block SHALL have parameter ADDR_W, default 8, program-counter width (ADDR_W <= DATA_W).
REQ-004 The block SHALL use INSTR_W = 4 + 2*RIDX_W + DATA_W, with fields {opcode[3:0], rd, rs, imm} from MSB to LSB.
REQ-005 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The block SHALL have port instr_addr  output  ADDR_W  fetch address, equal to PC.
REQ-008 The block SHALL have port instr_req  output  1  fetch request.
REQ-009 The block SHALL have port instr_valid  input  1  instr_data valid for the current request.
REQ-010 The block SHALL have port instr_data  input  INSTR_W  fetched instruction.
REQ-011 The block SHALL have port result  output  DATA_W  last ALU/load result written.
REQ-012 The block SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-013 The block SHALL have ports zero_flag, carry_flag  output  1 each  registered ALU flags.
REQ-014 The block SHALL have port halted  output  1  high in HALT state.
REQ-015 The block SHALL have port illegal  output  1  sticky, set by an undefined opcode.

Function
REQ-016 The FSM SHALL have states FETCH, EXEC, HALT.
REQ-017 FETCH: instr_req=1 and instr_addr=PC held stable; on instr_valid, capture instr_data and go to EXEC; otherwise wait indefinitely.
REQ-018 instr_valid outside FETCH SHALL be ignored.
REQ-019 EXEC SHALL last exactly one cycle, with instr_req=0; minimum instruction time is 2 cycles.
REQ-020 Opcodes: 0 NOP; 1 LDI rd=imm; 2 ADD rd=rd+rs; 3 SUB rd=rd-rs; 4 AND; 5 OR; 6 XOR; 7 MOV rd=rs; 8 JMP PC=imm[ADDR_W-1:0]; 9 JZ (jump if zero_flag); 10 JC (jump if carry_flag); 15 HALT.
REQ-021 Opcodes 11..14 SHALL execute as NOP and set illegal.
REQ-022 Non-jump and untaken-jump instructions SHALL set PC=PC+1 modulo 2^ADDR_W; PC SHALL wrap from all-ones to 0.
REQ-023 ADD carry SHALL be the carry-out of the DATA_W-bit sum; SUB carry SHALL be the borrow (rd<rs unsigned); logic ops, MOV and LDI SHALL clear carry.
REQ-024 zero_flag SHALL be set iff the written value is 0 for opcodes 1..7; flags SHALL be unchanged by NOP, jumps and HALT.
REQ-025 Register reads in EXEC SHALL use pre-write values, so rd==rs is legal (SUB r,r gives 0, zero=1, carry=0).
REQ-026 For opcodes 1..7, result SHALL equal the written value and result_valid SHALL pulse in the cycle after EXEC.
REQ-027 HALT opcode SHALL enter HALT with PC frozen at the HALT address; the only exit SHALL be reset; halted=1 and instr_req=0 there.
REQ-028 Combinational outputs SHALL have no paths from instr_data to any output.

Reset
REQ-029 Reset SHALL force: state FETCH, PC 0, all registers 0, result 0, result_valid 0, flags 0, halted 0, illegal 0.
REQ-030 Reset asserted mid-fetch or mid-EXEC SHALL abort the instruction with no register, flag or PC update; the first fetch after release SHALL be at address 0.

Structure
REQ-031 Opcode encodings and the FSM state enum SHALL reside in shared package mpu_pkg.
REQ-032 The arithmetic/logic datapath SHALL be a parametrised sub-module mpu_alu (DATA_W), combinational, returning value, carry and zero.

Verification
REQ-033 Verification SHALL check reset: after rst release, instr_addr=0, instr_req=1, all outputs 0.
REQ-034 Verification SHALL run, with DATA_W=8, the program LDI r0,200; LDI r1,100; ADD r0,r1 -> result=44, carry=1, zero=0, result_valid pulses 3 times.
REQ-035 Verification SHALL run LDI r2,5; SUB r2,r2; JZ 0x10 -> PC becomes 0x10; zero=1, carry=0.
REQ-036 Verification SHALL hold instr_valid low for 5 cycles in FETCH -> instr_addr stable, no state change; then a HALT at 0x07 -> halted=1, instr_req=0 for 20 cycles.
REQ-037 Verification SHALL check wrap with ADDR_W=4: a NOP at 0xF -> next instr_addr=0x0; opcode 12 -> illegal=1, registers unchanged.
REQ-038 Verification SHALL assert rst during EXEC of an ADD -> target register and flags remain 0; refetch at address 0.
